// File: rtl/dma_utils_pkg.sv
// Shared types and helpers for the DMA burst generator.
// Burst mode, FSM states and data-width helpers.
package dma_utils_pkg;

  typedef enum logic {
    MODE_INCR  = 1'b0,
    MODE_FIXED = 1'b1
  } dma_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dma_bg_st_t;

  localparam int unsigned PAGE_BYTES  = 4096;
  localparam int unsigned FIXED_BEATS = 16;

  function automatic int unsigned bpb_of(
    input int unsigned dw
  );
    return dw / 8;
  endfunction

  function automatic logic [2:0] size_of(
    input int unsigned dw
  );
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      if ((dw / 8) == (32'd1 << i)) begin
        s = 3'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/dma_burst_gen_if.sv
// AXI AR/AW request channel plus completion strobe.
// Master drives the request, slave drives ready and cpl.
interface dma_burst_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);

  logic                    valid;
  logic                    ready;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [7:0]              alen;
  logic [2:0]              size;
  logic                    mode;
  logic [DATA_WIDTH/8-1:0] strb;
  logic                    cpl;

  modport master (
    output valid, addr, alen, size, mode, strb,
    input  ready, cpl
  );

  modport slave (
    input  valid, addr, alen, size, mode, strb,
    output ready, cpl
  );

endinterface

// File: rtl/dma_burst_calc.sv
// Sizes the next AXI request from the cursor:
// unaligned head, capped aligned burst, or tail.
module dma_burst_calc
  import dma_utils_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int BYTES_WIDTH    = 32,
  parameter int MAX_BEAT_BURST = 256
) (
  input  logic [11:0]             addr_lo,
  input  logic [BYTES_WIDTH-1:0]  bytes,
  input  dma_mode_t               mode,
  input  logic [7:0]              maxb,
  output logic [7:0]              alen,
  output logic [DATA_WIDTH/8-1:0] strb,
  output logic [BYTES_WIDTH-1:0]  txn_bytes
);

  localparam int BPB  = int'(bpb_of(DATA_WIDTH));
  localparam int OFFW = $clog2(BPB);
  localparam int SW   = BPB;
  localparam int BW   = BYTES_WIDTH;

  logic [OFFW-1:0] off;
  logic [BW-1:0]   room;
  logic [BW-1:0]   n_head;
  logic [BW-1:0]   beats;
  logic [BW-1:0]   page;
  logic [SW:0]     mask;

  assign off = addr_lo[OFFW-1:0];

  // Pick head / burst / tail and clamp burst beats.
  always_comb begin
    alen      = '0;
    strb      = '0;
    txn_bytes = '0;
    n_head    = '0;
    beats     = '0;
    mask      = '0;
    room      = BW'(BPB) - BW'(off);
    page      = (BW'(PAGE_BYTES) - BW'(addr_lo)) >> OFFW;
    if (off != '0) begin
      n_head    = (bytes < room) ? bytes : room;
      mask      = ((SW+1)'(1) << n_head) - (SW+1)'(1);
      strb      = mask[SW-1:0] << off;
      txn_bytes = n_head;
    end else if (bytes >= BW'(BPB)) begin
      beats = bytes >> OFFW;
      if (beats > BW'(MAX_BEAT_BURST)) begin
        beats = BW'(MAX_BEAT_BURST);
      end
      if (beats > BW'(maxb) + BW'(1)) begin
        beats = BW'(maxb) + BW'(1);
      end
      if (mode == MODE_FIXED && beats > BW'(FIXED_BEATS)) begin
        beats = BW'(FIXED_BEATS);
      end
      if (beats > page) begin
        beats = page;
      end
      alen      = 8'(beats - BW'(1));
      strb      = '1;
      txn_bytes = beats << OFFW;
    end else if (bytes != '0) begin
      mask      = ((SW+1)'(1) << bytes) - (SW+1)'(1);
      strb      = mask[SW-1:0];
      txn_bytes = bytes;
    end
  end

endmodule

// File: rtl/dma_burst_gen.sv
// DMA address-phase generator: splits a descriptor into
// AXI requests with outstanding limit and abort drain.
module dma_burst_gen
  import dma_utils_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int BYTES_WIDTH    = 32,
  parameter int MAX_BEAT_BURST = 256,
  parameter int OUTST_MAX      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  start_addr_i,
  input  logic [BYTES_WIDTH-1:0] start_bytes_i,
  input  logic                   start_mode_i,
  input  logic [7:0]             maxb_i,
  input  logic                   abort_i,
  dma_burst_gen_if.master        req,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   aborted_o
);

  localparam int AW   = ADDR_WIDTH;
  localparam int BW   = BYTES_WIDTH;
  localparam int BPB  = int'(bpb_of(DATA_WIDTH));
  localparam int OFFW = $clog2(BPB);
  localparam int SW   = BPB;
  localparam int OW   = $clog2(OUTST_MAX + 1);
  localparam logic [2:0] SIZE = size_of(DATA_WIDTH);

  dma_bg_st_t state;
  dma_bg_st_t state_nx;

  logic [AW-1:0] cur_addr;
  logic [BW-1:0] cur_bytes;
  dma_mode_t     cur_mode;
  logic [OW-1:0] outst;
  logic          abort_q;

  logic          valid_r;
  logic [AW-1:0] addr_r;
  logic [7:0]    alen_r;
  logic [2:0]    size_r;
  dma_mode_t     mode_r;
  logic [SW-1:0] strb_r;
  logic          done_r;
  logic          aborted_r;

  logic [AW-1:0] c_addr;
  logic [BW-1:0] c_bytes;
  dma_mode_t     c_mode;
  logic [7:0]    c_alen;
  logic [SW-1:0] c_strb;
  logic [BW-1:0] c_txn;

  logic accept;
  logic start_go;
  logic abort_eff;
  logic gate;
  logic load;
  logic cpl_ok;

  assign accept    = valid_r && req.ready;
  assign start_go  = (state == IDLE) && start_i;
  assign abort_eff = (state == RUN) && (abort_i || abort_q);
  assign gate      = (outst + OW'(accept)) < OW'(OUTST_MAX);
  assign cpl_ok    = req.cpl && (outst != '0);

  // In IDLE the calculator sees the descriptor directly,
  // so the first request is registered on the start edge.
  assign c_addr  = (state == IDLE) ? start_addr_i : cur_addr;
  assign c_bytes = (state == IDLE) ? start_bytes_i : cur_bytes;
  assign c_mode  = (state == IDLE) ? dma_mode_t'(start_mode_i)
                                   : cur_mode;

  assign load = start_go ? (start_bytes_i != '0)
              : ((state == RUN) && !abort_eff &&
                 (cur_bytes != '0) && (!valid_r || accept) &&
                 gate);

  dma_burst_calc #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BYTES_WIDTH    (BYTES_WIDTH),
    .MAX_BEAT_BURST (MAX_BEAT_BURST)
  ) u_calc (
    .addr_lo   (c_addr[11:0]),
    .bytes     (c_bytes),
    .mode      (c_mode),
    .maxb      (maxb_i),
    .alen      (c_alen),
    .strb      (c_strb),
    .txn_bytes (c_txn)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: leave RUN once nothing more will issue.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_nx = (start_bytes_i == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept && cur_bytes == '0) begin
          state_nx = DRAIN;
        end else if (abort_eff && (!valid_r || accept)) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (outst == '0) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Cursor holds what is still left to present.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_addr  <= '0;
      cur_bytes <= '0;
      cur_mode  <= MODE_INCR;
    end else begin
      if (start_go) begin
        cur_mode <= dma_mode_t'(start_mode_i);
      end
      if (load) begin
        cur_bytes <= c_bytes - c_txn;
        cur_addr  <= (c_mode == MODE_INCR)
                   ? c_addr + AW'(c_txn) : c_addr;
      end else if (start_go) begin
        cur_addr  <= start_addr_i;
        cur_bytes <= start_bytes_i;
      end
    end
  end

  // Request register: payload frozen until accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_r <= 1'b0;
      addr_r  <= '0;
      alen_r  <= '0;
      size_r  <= '0;
      mode_r  <= MODE_INCR;
      strb_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      addr_r  <= {c_addr[AW-1:OFFW], {OFFW{1'b0}}};
      alen_r  <= c_alen;
      size_r  <= SIZE;
      mode_r  <= c_mode;
      strb_r  <= c_strb;
    end else if (accept) begin
      valid_r <= 1'b0;
    end
  end

  // Outstanding count: +1 accept, -1 credited completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      outst <= '0;
    end else begin
      unique case (1'b1)
        accept && !cpl_ok: outst <= outst + OW'(1);
        !accept && cpl_ok: outst <= outst - OW'(1);
        default:           outst <= outst;
      endcase
    end
  end

  // Latch abort seen while running until back in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      abort_q <= 1'b0;
    end else if (state == IDLE) begin
      abort_q <= 1'b0;
    end else if (state == RUN && abort_i) begin
      abort_q <= 1'b1;
    end
  end

  // Completion pulse on the DRAIN to IDLE transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      done_r    <= (state == DRAIN) && (outst == '0);
      aborted_r <= (state == DRAIN) && (outst == '0) && abort_q;
    end
  end

  assign req.valid = valid_r;
  assign req.addr  = addr_r;
  assign req.alen  = alen_r;
  assign req.size  = size_r;
  assign req.mode  = mode_r;
  assign req.strb  = strb_r;
  assign busy_o    = (state != IDLE);
  assign done_o    = done_r;
  assign aborted_o = aborted_r;

endmodule
